window_gen_3x3: RTL

- Upstream neighbour of the 3x3 pixel filter.
- Converts a raster-order pixel stream (one 12-bit pixel per accepted cycle) into a registered 3x3 neighbourhood p0..p8 plus centre coordinates, for direct connection to the filter's pixel inputs.
- Buffers two previous image rows internally. Emits windows only for interior pixels (no border padding).

---
 rtl/window_pkg.sv | 21 ++
 rtl/line_buffer.sv | 35 +++
 rtl/window_gen_3x3.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared types and defaults for the 3x3 window generator and filter side
//
// Purpose: common pixel/coordinate width defaults, the nine-pixel window
// array type, and a small helper that decides whether an accepted pixel
// completes an interior window.
package window_pkg;

  localparam int PIX_W_DEF   = 12;
  localparam int COORD_W_DEF = 11;
  localparam int WIN_N       = 9;

  // Nine-pixel neighbourhood; index k holds pk (p0 = top-left, p8 = bottom-right).
  typedef logic [WIN_N-1:0][PIX_W_DEF-1:0] window_t;

  // A window is centred one column and one row behind the accepted pixel,
  // so it exists only once two full columns and two full rows are behind us.
  function automatic logic completes_window(input int unsigned col, input int unsigned row);
    return (col >= 2) && (row >= 2);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port row buffer with combinational read-before-write
//
// Purpose: holds one image row. The read of the addressed entry is
// combinational and reflects the contents before this cycle's write.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   entry index (column)
//   wdata  in   data written at addr on the rising edge when we=1
//   rdata  out  current contents at addr (old value during a write)
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // Deliberately unreset: contents are only ever observed after a full row
  // has been rewritten at every index.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster pixel stream to registered 3x3 interior neighbourhood
//
// Purpose: buffers two previous rows and emits, one cycle after each
// accepted interior-completing pixel, the 3x3 window centred one column and
// one row behind it, together with the centre coordinates.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   in_valid    in   pixel present (always accepted)
//   in_sof      in   start of frame, forces the current pixel to (0,0)
//   in_pixel    in   pixel data
//   p0..p8      out  window; p0..p2 row y-1, p3..p5 row y, p6..p8 row y+1
//   out_valid   out  window valid this cycle
//   out_x       out  centre column
//   out_y       out  centre row
//   frame_done  out  pulse with the last window of a frame
module window_gen_3x3
  import window_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic [PIX_W-1:0]   p0,
  output logic [PIX_W-1:0]   p1,
  output logic [PIX_W-1:0]   p2,
  output logic [PIX_W-1:0]   p3,
  output logic [PIX_W-1:0]   p4,
  output logic [PIX_W-1:0]   p5,
  output logic [PIX_W-1:0]   p6,
  output logic [PIX_W-1:0]   p7,
  output logic [PIX_W-1:0]   p8,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 1);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] cur_col, cur_row;

  // Column shift registers, index 0 oldest (left), index 2 newest (right).
  logic [2:0][PIX_W-1:0] top_q, top_d;
  logic [2:0][PIX_W-1:0] mid_q, mid_d;
  logic [2:0][PIX_W-1:0] bot_q, bot_d;

  logic [WIN_N-1:0][PIX_W-1:0] win_q, win_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [COORD_W-1:0] out_x_q, out_x_d;
  logic [COORD_W-1:0] out_y_q, out_y_d;

  logic               lb_we;
  logic [AW-1:0]      lb_addr;
  logic [PIX_W-1:0]   old_a;
  logic [PIX_W-1:0]   old_b;

  // in_sof overrides the counters for the pixel that carries it, which is
  // what abandons a partial frame.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;

  // A pixel arriving together with reset is dropped, including its RAM write.
  assign lb_we   = in_valid && !reset;
  assign lb_addr = cur_col[AW-1:0];

  // lb_a holds the previous row; lb_b receives what lb_a held, i.e. row-2.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) u_lb_a (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (in_pixel),
    .rdata (old_a)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) u_lb_b (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (old_a),
    .rdata (old_b)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    top_d        = top_q;
    mid_d        = mid_q;
    bot_d        = bot_q;
    win_d        = win_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (in_valid) begin
      // Shifting also happens at col 0; the stale left entries that brings
      // in are never emitted because a window needs col >= 2.
      top_d = {old_b,    top_q[2:1]};
      mid_d = {old_a,    mid_q[2:1]};
      bot_d = {in_pixel, bot_q[2:1]};

      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + COORD_W'(1);
      end else begin
        col_d = cur_col + COORD_W'(1);
        row_d = cur_row;
      end

      if (completes_window(int'(cur_col), int'(cur_row))) begin
        // Taken from the post-shift view: the two older entries plus the
        // values arriving this cycle.
        win_d[0] = top_q[1];
        win_d[1] = top_q[2];
        win_d[2] = old_b;
        win_d[3] = mid_q[1];
        win_d[4] = mid_q[2];
        win_d[5] = old_a;
        win_d[6] = bot_q[1];
        win_d[7] = bot_q[2];
        win_d[8] = in_pixel;
        out_x_d      = cur_col - COORD_W'(1);
        out_y_d      = cur_row - COORD_W'(1);
        out_valid_d  = 1'b1;
        frame_done_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      win_q        <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      win_q        <= win_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign p0         = win_q[0];
  assign p1         = win_q[1];
  assign p2         = win_q[2];
  assign p3         = win_q[3];
  assign p4         = win_q[4];
  assign p5         = win_q[5];
  assign p6         = win_q[6];
  assign p7         = win_q[7];
  assign p8         = win_q[8];
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign frame_done = frame_done_q;

endmodule
